// File: rtl/touch_screen_clk_pkg.sv
// Shared definitions for the touch-screen fabric clock/reset generator:
// sequencer state encoding, lock-loss counter sizing and a counter-width helper.
package touch_screen_clk_pkg;

  typedef enum logic [1:0] {
    SEQ_RST       = 2'b00,
    SEQ_WAIT_LOCK = 2'b01,
    SEQ_STRETCH   = 2'b10,
    SEQ_RUN       = 2'b11
  } seq_state_e;

  localparam int unsigned             LOCK_CNT_W   = 8;
  localparam logic [LOCK_CNT_W-1:0]   LOCK_CNT_MAX = 8'd255;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/touch_screen_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module touch_screen_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_q <= 2'b00;
    end else begin
      r_sync_q <= {r_sync_q[0], i_d};
    end
  end

  assign o_q = r_sync_q[1];

endmodule

// File: rtl/touch_screen_fab_clk_rst_gen.sv
// Fabric clock/reset generator for the touch-screen block: qualifies the CCC lock,
// sequences FAB_RESET_N, produces SAMPLE_TICK/SLOW_TICK and counts lock losses.
// Build option: TOUCH_SCREEN_LOCK_BYPASS_EN ignores FAB_LOCK (treated as always locked).
module touch_screen_fab_clk_rst_gen
  import touch_screen_clk_pkg::*;
#(
  parameter int unsigned LOCK_FILT   = 4,
  parameter int unsigned RST_STRETCH = 16,
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned SLOW_DIV    = 100
) (
  input  logic                  FAB_CLK,
  input  logic                  MSS_RESET_N,
  input  logic                  FAB_LOCK,
  input  logic                  SW_RESET_REQ,
  output logic                  FAB_RESET_N,
  output logic                  CLK_READY,
  output logic                  SAMPLE_TICK,
  output logic                  SLOW_TICK,
  output logic [LOCK_CNT_W-1:0] LOCK_LOST_CNT,
  output logic [1:0]            SEQ_STATE
);

  localparam int unsigned FILT_W = cnt_width(LOCK_FILT);
  localparam int unsigned STR_W  = cnt_width(RST_STRETCH);
  localparam int unsigned TICK_W = cnt_width(TICK_DIV);
  localparam int unsigned SLOW_W = cnt_width(SLOW_DIV);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(RST_STRETCH - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

  logic w_rst_sync;
  logic w_lock_s;

  // Reset release is synchronized; the sequencer leaves RST only once it is seen.
  touch_screen_sync2 u_rst_sync (
    .i_clk   (FAB_CLK),
    .i_rst_n (MSS_RESET_N),
    .i_d     (1'b1),
    .o_q     (w_rst_sync)
  );

`ifdef TOUCH_SCREEN_LOCK_BYPASS_EN
  // PLL bypassed: FAB_LOCK is tied low on these builds, so treat the clock as locked.
  logic w_unused_lock;
  assign w_unused_lock = FAB_LOCK;
  assign w_lock_s      = 1'b1;
`else
  touch_screen_sync2 u_lock_sync (
    .i_clk   (FAB_CLK),
    .i_rst_n (MSS_RESET_N),
    .i_d     (FAB_LOCK),
    .o_q     (w_lock_s)
  );
`endif

  seq_state_e            r_state_q, w_state_d;
  logic [FILT_W-1:0]     r_filt_q, w_filt_d;
  logic [STR_W-1:0]      r_str_q, w_str_d;
  logic [TICK_W-1:0]     r_tick_q, w_tick_d;
  logic [SLOW_W-1:0]     r_slow_q, w_slow_d;
  logic [LOCK_CNT_W-1:0] r_lost_q, w_lost_d;
  logic                  r_run_q;
  logic                  r_sample_q;
  logic                  r_slow_tick_q;
  logic                  w_stay_run;
  logic                  w_tick_wrap;
  logic                  w_slow_wrap;

  // Sequencer next state, filter/stretch counters and lock-loss count.
  always_comb begin
    w_state_d = r_state_q;
    w_filt_d  = '0;
    w_str_d   = '0;
    w_lost_d  = r_lost_q;
    case (r_state_q)
      SEQ_RST: begin
        if (w_rst_sync) w_state_d = SEQ_WAIT_LOCK;
      end
      SEQ_WAIT_LOCK: begin
        // Any low lock_s cycle leaves the filter at 0.
        if (w_lock_s) begin
          if (r_filt_q == FILT_LAST) w_state_d = SEQ_STRETCH;
          else                       w_filt_d  = r_filt_q + 1'b1;
        end
      end
      SEQ_STRETCH: begin
        if (!w_lock_s)                  w_state_d = SEQ_WAIT_LOCK;
        else if (r_str_q == STR_LAST)   w_state_d = SEQ_RUN;
        else                            w_str_d   = r_str_q + 1'b1;
      end
      SEQ_RUN: begin
        // Lock loss takes priority over a software re-sequence request.
        if (!w_lock_s) begin
          w_state_d = SEQ_WAIT_LOCK;
          if (r_lost_q != LOCK_CNT_MAX) w_lost_d = r_lost_q + 1'b1;
        end else if (SW_RESET_REQ) begin
          w_state_d = SEQ_STRETCH;
        end
      end
      default: w_state_d = SEQ_RST;
    endcase
  end

  // Ticks only advance while RUN is held across the edge; otherwise counters clear.
  assign w_stay_run  = (r_state_q == SEQ_RUN) && (w_state_d == SEQ_RUN);
  assign w_tick_wrap = w_stay_run && (r_tick_q == TICK_LAST);
  assign w_slow_wrap = w_tick_wrap && (r_slow_q == SLOW_LAST);

  // Timebase counter next values.
  always_comb begin
    w_tick_d = '0;
    w_slow_d = '0;
    if (w_stay_run) begin
      w_tick_d = w_tick_wrap ? '0 : r_tick_q + 1'b1;
      w_slow_d = r_slow_q;
      if (w_tick_wrap) w_slow_d = w_slow_wrap ? '0 : r_slow_q + 1'b1;
    end
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_state_q     <= SEQ_RST;
      r_filt_q      <= '0;
      r_str_q       <= '0;
      r_tick_q      <= '0;
      r_slow_q      <= '0;
      r_lost_q      <= '0;
      r_run_q       <= 1'b0;
      r_sample_q    <= 1'b0;
      r_slow_tick_q <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_filt_q      <= w_filt_d;
      r_str_q       <= w_str_d;
      r_tick_q      <= w_tick_d;
      r_slow_q      <= w_slow_d;
      r_lost_q      <= w_lost_d;
      r_run_q       <= (w_state_d == SEQ_RUN);
      r_sample_q    <= w_tick_wrap;
      r_slow_tick_q <= w_slow_wrap;
    end
  end

  assign FAB_RESET_N   = r_run_q;
  assign CLK_READY     = r_run_q;
  assign SAMPLE_TICK   = r_sample_q;
  assign SLOW_TICK     = r_slow_tick_q;
  assign LOCK_LOST_CNT = r_lost_q;
  assign SEQ_STATE     = r_state_q;

endmodule

// File: tb/tb_touch_screen_fab_clk_rst_gen.sv
// Directed bench for touch_screen_fab_clk_rst_gen. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the outputs are sampled.
module tb_touch_screen_fab_clk_rst_gen;

  localparam int LOCK_FILT   = 4;
  localparam int RST_STRETCH = 16;
  localparam int TICK_DIV    = 10;
  localparam int SLOW_DIV    = 3;

  logic       FAB_CLK;
  logic       MSS_RESET_N;
  logic       FAB_LOCK;
  logic       SW_RESET_REQ;
  logic       FAB_RESET_N;
  logic       CLK_READY;
  logic       SAMPLE_TICK;
  logic       SLOW_TICK;
  logic [7:0] LOCK_LOST_CNT;
  logic [1:0] SEQ_STATE;

  touch_screen_fab_clk_rst_gen #(
    .LOCK_FILT   (LOCK_FILT),
    .RST_STRETCH (RST_STRETCH),
    .TICK_DIV    (TICK_DIV),
    .SLOW_DIV    (SLOW_DIV)
  ) dut (
    .FAB_CLK       (FAB_CLK),
    .MSS_RESET_N   (MSS_RESET_N),
    .FAB_LOCK      (FAB_LOCK),
    .SW_RESET_REQ  (SW_RESET_REQ),
    .FAB_RESET_N   (FAB_RESET_N),
    .CLK_READY     (CLK_READY),
    .SAMPLE_TICK   (SAMPLE_TICK),
    .SLOW_TICK     (SLOW_TICK),
    .LOCK_LOST_CNT (LOCK_LOST_CNT),
    .SEQ_STATE     (SEQ_STATE)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty got=%0h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) begin
        n_pass++;
      end else begin
        $error("FAIL %s got=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change and outputs are sampled just after falling edges.
  task automatic step();
    @(negedge FAB_CLK);
  endtask

  // Sequencer state after edge n following reset release, STRETCH first shown at edge s.
  // Edges 1-2 fill the reset synchronizer (lock synchronizer fills in parallel),
  // edge 3 leaves RST, LOCK_FILT qualifying edges, then RST_STRETCH edges of STRETCH.
  function automatic logic [1:0] exp_state(input int n, input int s);
    if (n < 3)               return 2'b00;
    if (n < s)               return 2'b01;
    if (n < s + RST_STRETCH) return 2'b10;
    return 2'b11;
  endfunction

  // Assert reset between clock edges and confirm outputs drop with no edge.
  task automatic async_reset_check(input string tag);
    #2 MSS_RESET_N = 1'b0;
    #1;
    expect_val({tag, "_rstn"},  32'd0);
    expect_val({tag, "_ready"}, 32'd0);
    expect_val({tag, "_samp"},  32'd0);
    expect_val({tag, "_slow"},  32'd0);
    expect_val({tag, "_lost"},  32'd0);
    expect_val({tag, "_state"}, 32'd0);
    check(32'(FAB_RESET_N));
    check(32'(CLK_READY));
    check(32'(SAMPLE_TICK));
    check(32'(SLOW_TICK));
    check(32'(LOCK_LOST_CNT));
    check(32'(SEQ_STATE));
  endtask

  task automatic release_reset(input logic lock);
    step();
    FAB_LOCK    = lock;
    MSS_RESET_N = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    for (int j = 0; j < 40 && !CLK_READY; j++) step();
    expect_val(tag, 32'd1);
    check(32'(CLK_READY));
  endtask

  // Per-edge walk of state and FAB_RESET_N from release; glitch optionally pulses lock.
  task automatic walk(input string tag, input int last, input int s, input bit glitch);
    for (int n = 1; n <= last; n++) begin
      expect_val({tag, "_state"}, 32'(exp_state(n, s)));
      expect_val({tag, "_rstn"},  32'(exp_state(n, s) == 2'b11));
      step();
      check(32'(SEQ_STATE));
      check(32'(FAB_RESET_N));
      // Low during edge 5 only -> lock_s low as the filter sits at 3.
      if (glitch && n == 4) FAB_LOCK = 1'b0;
      if (glitch && n == 5) FAB_LOCK = 1'b1;
    end
  endtask

  // Cycle k after a known RUN entry (tick counter at 0): check both tick outputs.
  task automatic tick_window(input string tag, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      expect_val({tag, "_sample"}, 32'(k % TICK_DIV == 0));
      expect_val({tag, "_slow"},   32'(k % (TICK_DIV * SLOW_DIV) == 0));
      step();
      check(32'(SAMPLE_TICK));
      check(32'(SLOW_TICK));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    MSS_RESET_N  = 1'b0;
    FAB_LOCK     = 1'b0;
    SW_RESET_REQ = 1'b0;
    step();
    async_reset_check("reset");

`ifdef TOUCH_SCREEN_LOCK_BYPASS_EN
    // Lock tied low must still qualify in bypass builds.
    release_reset(1'b0);
    walk("bypass", 25, 3 + LOCK_FILT, 1'b0);
    repeat (20) step();
    expect_val("bypass_ready", 32'd1);
    expect_val("bypass_lost",  32'd0);
    check(32'(CLK_READY));
    check(32'(LOCK_LOST_CNT));
`else
    // 1. Bring-up: RUN and FAB_RESET_N high exactly at edge 23.
    release_reset(1'b1);
    walk("bringup", 25, 3 + LOCK_FILT, 1'b0);

    // 2. Lock glitch at filter count 3: filter restarts, STRETCH at edge 11, RUN at 27.
    async_reset_check("reset2");
    release_reset(1'b1);
    walk("glitch", 27, 3 + LOCK_FILT + 4, 1'b1);

    // 3. Ticks for 60 cycles from RUN entry.
    tick_window("tick", 60);
    repeat (13) step();  // leaves tick and slow counters mid-count

    // 4. Lock loss: FAB_RESET_N falls on the third edge.
    FAB_LOCK = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      expect_val("loss_state", (j < 3) ? 32'd3 : 32'd1);
      expect_val("loss_rstn",  (j < 3) ? 32'd1 : 32'd0);
      step();
      check(32'(SEQ_STATE));
      check(32'(FAB_RESET_N));
    end
    expect_val("loss_cnt",    32'd1);
    expect_val("loss_ready",  32'd0);
    expect_val("loss_sample", 32'd0);
    check(32'(LOCK_LOST_CNT));
    check(32'(CLK_READY));
    check(32'(SAMPLE_TICK));
    // Reacquire: 2 sync edges + LOCK_FILT + RST_STRETCH edges to RUN.
    FAB_LOCK = 1'b1;
    for (int j = 1; j <= 2 + LOCK_FILT + RST_STRETCH; j++) begin
      expect_val("reacq_ready", 32'(j == 2 + LOCK_FILT + RST_STRETCH));
      step();
      check(32'(CLK_READY));
    end
    // Cleared counters: first ticks land at the same offsets as a fresh RUN.
    tick_window("retick", 30);

    // 5. SW reset: STRETCH for RST_STRETCH cycles, then RUN; count unchanged.
    SW_RESET_REQ = 1'b1;
    for (int j = 0; j <= RST_STRETCH; j++) begin
      expect_val("sw_state", (j == RST_STRETCH) ? 32'd3 : 32'd2);
      expect_val("sw_rstn",  32'(j == RST_STRETCH));
      step();
      SW_RESET_REQ = 1'b0;
      check(32'(SEQ_STATE));
      check(32'(FAB_RESET_N));
    end
    expect_val("sw_cnt", 32'd1);
    check(32'(LOCK_LOST_CNT));

    // SW request on the cycle lock_s falls: lock loss wins.
    FAB_LOCK = 1'b0;
    step();
    step();
    SW_RESET_REQ = 1'b1;
    step();
    SW_RESET_REQ = 1'b0;
    expect_val("both_state", 32'd1);
    expect_val("both_cnt",   32'd2);
    check(32'(SEQ_STATE));
    check(32'(LOCK_LOST_CNT));
    // SW request outside RUN is ignored.
    SW_RESET_REQ = 1'b1;
    step();
    SW_RESET_REQ = 1'b0;
    expect_val("sw_idle_state", 32'd1);
    check(32'(SEQ_STATE));

    // Repeated losses up to 300 total: count saturates at 255.
    for (int i = 3; i <= 300; i++) begin
      FAB_LOCK = 1'b1;
      wait_ready("rep_ready");
      FAB_LOCK = 1'b0;
      repeat (3) step();
      expect_val("rep_cnt", 32'((i > 255) ? 255 : i));
      check(32'(LOCK_LOST_CNT));
    end

    // 6. Async reset mid-RUN and mid-STRETCH.
    FAB_LOCK = 1'b1;
    wait_ready("pre_async_ready");
    repeat (5) step();
    async_reset_check("async_run");
    release_reset(1'b1);
    repeat (12) step();
    expect_val("pre_async_stretch", 32'd2);
    check(32'(SEQ_STATE));
    async_reset_check("async_stretch");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
